// File: rtl/branch_resolve_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : branch_resolve_ctrl_pkg
//  Description : Shared widths, FSM encoding and payload structs for the
//                branch resolution controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package branch_resolve_ctrl_pkg;

   localparam int EPOCH_W = 2;
   localparam int ROB_W   = 5;
   localparam int PHYS_W  = 6;

   typedef enum logic [1:0] {
      BRC_IDLE     = 2'd0,
      BRC_FLUSH    = 2'd1,
      BRC_REDIRECT = 2'd2
   } brc_state_t;

   typedef struct packed {
      logic                 uses_rd;
      logic [EPOCH_W-1:0]   epoch;
      logic [ROB_W-1:0]     rob_idx;
      logic [PHYS_W-1:0]    prd;
      logic [31:0]          data;
   } cdb_entry_t;

   typedef struct packed {
      logic [31:0] pc;
      logic        taken;
      logic [31:0] target;
   } bp_update_t;

endpackage
`default_nettype wire

// File: rtl/cdb_out_buf.sv
`default_nettype none
// ============================================================================
//  Module      : cdb_out_buf
//  Description : Single-entry valid/ready output register. A load in the same
//                cycle as a drain replaces the entry without a bubble.
//  Revision    : 1.0 - initial release
// ============================================================================
module cdb_out_buf
   import branch_resolve_ctrl_pkg::*;
#(
   parameter type T = cdb_entry_t
) (
   input  logic clk,
   input  logic rst,
   input  logic load_valid,
   input  T     load_data,
   input  logic drain_ready,
   output logic buf_valid,
   output T     buf_data
);

   logic r_valid;
   T     r_data;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid <= 1'b0;
         r_data  <= '0;
      end else if (load_valid) begin
         r_valid <= 1'b1;
         r_data  <= load_data;
      end else if (drain_ready && r_valid) begin
         r_valid <= 1'b0;
      end
   end

   assign buf_valid = r_valid;
   assign buf_data  = r_data;

endmodule
`default_nettype wire

// File: rtl/branch_resolve_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : branch_resolve_ctrl
//  Description : Accepts branch unit results, drops stale-epoch ones, forwards
//                live ones to the CDB and runs flush/redirect on a mispredict.
//  Revision    : 1.0 - initial release
// ============================================================================
module branch_resolve_ctrl
   import branch_resolve_ctrl_pkg::*;
#(
   parameter int FLUSH_CYCLES = 2
) (
   input  logic               clk,
   input  logic               rst,

   input  logic               bru_wb_valid,
   output logic               bru_wb_ready,
   input  logic               bru_wb_uses_rd,
   input  logic [EPOCH_W-1:0] bru_wb_epoch,
   input  logic [ROB_W-1:0]   bru_wb_rob_idx,
   input  logic [PHYS_W-1:0]  bru_wb_prd_new,
   input  logic [31:0]        bru_wb_data,
   input  logic [31:0]        bru_wb_pc,
   input  logic               bru_act_taken,
   input  logic [31:0]        bru_target_pc,
   input  logic               bru_mispredict,
   input  logic [31:0]        bru_redirect_pc,

   output logic               cdb_valid,
   input  logic               cdb_ready,
   output logic               cdb_uses_rd,
   output logic [EPOCH_W-1:0] cdb_epoch,
   output logic [ROB_W-1:0]   cdb_rob_idx,
   output logic [PHYS_W-1:0]  cdb_prd,
   output logic [31:0]        cdb_data,

   output logic               bp_upd_valid,
   output logic [31:0]        bp_upd_pc,
   output logic               bp_upd_taken,
   output logic [31:0]        bp_upd_target,

   output logic               flush_valid,
   output logic [ROB_W-1:0]   flush_rob_idx,
   output logic [EPOCH_W-1:0] cur_epoch,

   output logic               fe_redirect_valid,
   input  logic               fe_redirect_ready,
   output logic [31:0]        fe_redirect_pc
);

   localparam int               c_CNT_W      = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
   localparam logic [c_CNT_W-1:0] c_FLUSH_LAST = c_CNT_W'(FLUSH_CYCLES - 1);

   brc_state_t           r_state;
   logic [EPOCH_W-1:0]   r_cur_epoch;
   logic [c_CNT_W-1:0]   r_flush_cnt;
   logic                 r_flush_valid;
   logic [ROB_W-1:0]     r_flush_rob_idx;
   logic                 r_fe_redirect_valid;
   logic [31:0]          r_redirect_pc;
   logic                 r_bp_upd_valid;
   bp_update_t           r_bp_upd;

   logic                 w_wb_ready;
   logic                 w_accept;
   logic                 w_current;
   logic                 w_take;
   logic                 w_mispredict;
   logic                 w_cdb_valid;
   cdb_entry_t           w_cdb_in;
   cdb_entry_t           w_cdb_out;

   // Ready is independent of bru_wb_valid so the producer may use it freely.
   always_comb begin
      w_wb_ready = (r_state == BRC_IDLE) && (!w_cdb_valid || cdb_ready);
   end

   assign w_accept     = bru_wb_valid && w_wb_ready;
   assign w_current    = (bru_wb_epoch == r_cur_epoch);
   assign w_take       = w_accept && w_current;
   assign w_mispredict = w_take && bru_mispredict;

   // The mispredicting branch itself is retained, so it carries the old epoch.
   always_comb begin
      w_cdb_in         = '0;
      w_cdb_in.uses_rd = bru_wb_uses_rd;
      w_cdb_in.epoch   = bru_wb_epoch;
      w_cdb_in.rob_idx = bru_wb_rob_idx;
      w_cdb_in.prd     = bru_wb_prd_new;
      w_cdb_in.data    = bru_wb_data;
   end

   cdb_out_buf #(
      .T (cdb_entry_t)
   ) u_cdb_out_buf (
      .clk         (clk),
      .rst         (rst),
      .load_valid  (w_take),
      .load_data   (w_cdb_in),
      .drain_ready (cdb_ready),
      .buf_valid   (w_cdb_valid),
      .buf_data    (w_cdb_out)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state             <= BRC_IDLE;
         r_cur_epoch         <= '0;
         r_flush_cnt         <= '0;
         r_flush_valid       <= 1'b0;
         r_flush_rob_idx     <= '0;
         r_fe_redirect_valid <= 1'b0;
         r_redirect_pc       <= '0;
         r_bp_upd_valid      <= 1'b0;
         r_bp_upd            <= '0;
      end else begin
         r_bp_upd_valid <= w_take;
         if (w_take) begin
            r_bp_upd.pc     <= bru_wb_pc;
            r_bp_upd.taken  <= bru_act_taken;
            r_bp_upd.target <= bru_target_pc;
         end

         case (r_state)
            BRC_IDLE: begin
               if (w_mispredict) begin
                  r_cur_epoch     <= r_cur_epoch + EPOCH_W'(1);
                  r_flush_rob_idx <= bru_wb_rob_idx;
                  r_redirect_pc   <= bru_redirect_pc;
                  r_flush_cnt     <= c_FLUSH_LAST;
                  r_flush_valid   <= 1'b1;
                  r_state         <= BRC_FLUSH;
               end
            end
            BRC_FLUSH: begin
               if (r_flush_cnt == '0) begin
                  r_flush_valid       <= 1'b0;
                  r_fe_redirect_valid <= 1'b1;
                  r_state             <= BRC_REDIRECT;
               end else begin
                  r_flush_cnt <= r_flush_cnt - c_CNT_W'(1);
               end
            end
            BRC_REDIRECT: begin
               if (fe_redirect_ready) begin
                  r_fe_redirect_valid <= 1'b0;
                  r_state             <= BRC_IDLE;
               end
            end
            default: begin
               r_flush_valid       <= 1'b0;
               r_fe_redirect_valid <= 1'b0;
               r_state             <= BRC_IDLE;
            end
         endcase
      end
   end

   assign bru_wb_ready      = w_wb_ready;

   assign cdb_valid         = w_cdb_valid;
   assign cdb_uses_rd       = w_cdb_out.uses_rd;
   assign cdb_epoch         = w_cdb_out.epoch;
   assign cdb_rob_idx       = w_cdb_out.rob_idx;
   assign cdb_prd           = w_cdb_out.prd;
   assign cdb_data          = w_cdb_out.data;

   assign bp_upd_valid      = r_bp_upd_valid;
   assign bp_upd_pc         = r_bp_upd.pc;
   assign bp_upd_taken      = r_bp_upd.taken;
   assign bp_upd_target     = r_bp_upd.target;

   assign flush_valid       = r_flush_valid;
   assign flush_rob_idx     = r_flush_rob_idx;
   assign cur_epoch         = r_cur_epoch;

   assign fe_redirect_valid = r_fe_redirect_valid;
   assign fe_redirect_pc    = r_redirect_pc;

endmodule
`default_nettype wire

// File: tb/tb_branch_resolve_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_branch_resolve_ctrl
//  Description : Directed self-checking bench for branch_resolve_ctrl.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_resolve_ctrl;
   import branch_resolve_ctrl_pkg::*;

   logic               clk = 1'b0;
   logic               rst;
   logic               bru_wb_valid;
   logic               bru_wb_ready;
   logic               bru_wb_uses_rd;
   logic [EPOCH_W-1:0] bru_wb_epoch;
   logic [ROB_W-1:0]   bru_wb_rob_idx;
   logic [PHYS_W-1:0]  bru_wb_prd_new;
   logic [31:0]        bru_wb_data;
   logic [31:0]        bru_wb_pc;
   logic               bru_act_taken;
   logic [31:0]        bru_target_pc;
   logic               bru_mispredict;
   logic [31:0]        bru_redirect_pc;
   logic               cdb_valid;
   logic               cdb_ready;
   logic               cdb_uses_rd;
   logic [EPOCH_W-1:0] cdb_epoch;
   logic [ROB_W-1:0]   cdb_rob_idx;
   logic [PHYS_W-1:0]  cdb_prd;
   logic [31:0]        cdb_data;
   logic               bp_upd_valid;
   logic [31:0]        bp_upd_pc;
   logic               bp_upd_taken;
   logic [31:0]        bp_upd_target;
   logic               flush_valid;
   logic [ROB_W-1:0]   flush_rob_idx;
   logic [EPOCH_W-1:0] cur_epoch;
   logic               fe_redirect_valid;
   logic               fe_redirect_ready;
   logic [31:0]        fe_redirect_pc;

   int n_vec = 0;
   int n_err = 0;

   branch_resolve_ctrl #(.FLUSH_CYCLES(2)) dut (
      .clk(clk), .rst(rst),
      .bru_wb_valid(bru_wb_valid), .bru_wb_ready(bru_wb_ready),
      .bru_wb_uses_rd(bru_wb_uses_rd), .bru_wb_epoch(bru_wb_epoch),
      .bru_wb_rob_idx(bru_wb_rob_idx), .bru_wb_prd_new(bru_wb_prd_new),
      .bru_wb_data(bru_wb_data), .bru_wb_pc(bru_wb_pc),
      .bru_act_taken(bru_act_taken), .bru_target_pc(bru_target_pc),
      .bru_mispredict(bru_mispredict), .bru_redirect_pc(bru_redirect_pc),
      .cdb_valid(cdb_valid), .cdb_ready(cdb_ready), .cdb_uses_rd(cdb_uses_rd),
      .cdb_epoch(cdb_epoch), .cdb_rob_idx(cdb_rob_idx), .cdb_prd(cdb_prd),
      .cdb_data(cdb_data),
      .bp_upd_valid(bp_upd_valid), .bp_upd_pc(bp_upd_pc),
      .bp_upd_taken(bp_upd_taken), .bp_upd_target(bp_upd_target),
      .flush_valid(flush_valid), .flush_rob_idx(flush_rob_idx),
      .cur_epoch(cur_epoch),
      .fe_redirect_valid(fe_redirect_valid), .fe_redirect_ready(fe_redirect_ready),
      .fe_redirect_pc(fe_redirect_pc)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [EPOCH_W-1:0] ep, input logic [ROB_W-1:0] rob,
                        input logic [PHYS_W-1:0] prd, input logic [31:0] data,
                        input logic [31:0] pc, input logic mis, input logic [31:0] rpc);
      bru_wb_valid    = 1'b1;
      bru_wb_uses_rd  = 1'b1;
      bru_wb_epoch    = ep;
      bru_wb_rob_idx  = rob;
      bru_wb_prd_new  = prd;
      bru_wb_data     = data;
      bru_wb_pc       = pc;
      bru_act_taken   = 1'b1;
      bru_target_pc   = pc + 32'h40;
      bru_mispredict  = mis;
      bru_redirect_pc = rpc;
   endtask

   // Mispredict from epoch ep with immediate redirect acceptance.
   task automatic mispredict_and_recover(input logic [EPOCH_W-1:0] ep, input logic [EPOCH_W-1:0] exp_next);
      bit done;
      drive(ep, 5'd1, 6'd1, 32'h8, 32'h4, 1'b1, 32'h4000);
      cdb_ready         = 1'b1;
      fe_redirect_ready = 1'b1;
      tick();
      bru_wb_valid = 1'b0;
      check("wrap_epoch", {62'd0, cur_epoch}, {62'd0, exp_next});
      done = 1'b0;
      for (int i = 0; i < 10 && !done; i++) begin
         if (bru_wb_ready) done = 1'b1;
         else tick();
      end
      check("wrap_recover_done", {63'd0, done}, 64'd1);
      fe_redirect_ready = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      bru_wb_valid = 1'b0; bru_wb_uses_rd = 1'b0; bru_wb_epoch = '0;
      bru_wb_rob_idx = '0; bru_wb_prd_new = '0; bru_wb_data = '0; bru_wb_pc = '0;
      bru_act_taken = 1'b0; bru_target_pc = '0; bru_mispredict = 1'b0;
      bru_redirect_pc = '0; cdb_ready = 1'b0; fe_redirect_ready = 1'b0;
      tick(); tick();
      rst = 1'b0;
      #1;
      check("rst_cdb_valid", {63'd0, cdb_valid}, 64'd0);
      check("rst_bp_valid", {63'd0, bp_upd_valid}, 64'd0);
      check("rst_flush", {63'd0, flush_valid}, 64'd0);
      check("rst_fe_valid", {63'd0, fe_redirect_valid}, 64'd0);
      check("rst_epoch", {62'd0, cur_epoch}, 64'd0);
      check("rst_fe_pc", {32'd0, fe_redirect_pc}, 64'd0);
      check("rst_ready", {63'd0, bru_wb_ready}, 64'd1);

      // Correct-path branch.
      drive(2'd0, 5'd5, 6'd12, 32'h104, 32'h100, 1'b0, 32'h0);
      cdb_ready = 1'b1;
      #1;
      check("ok_ready", {63'd0, bru_wb_ready}, 64'd1);
      tick();
      bru_wb_valid = 1'b0;
      check("ok_cdb_valid", {63'd0, cdb_valid}, 64'd1);
      check("ok_cdb_rob", {59'd0, cdb_rob_idx}, 64'd5);
      check("ok_cdb_prd", {58'd0, cdb_prd}, 64'd12);
      check("ok_cdb_data", {32'd0, cdb_data}, 64'h104);
      check("ok_bp_valid", {63'd0, bp_upd_valid}, 64'd1);
      check("ok_bp_pc", {32'd0, bp_upd_pc}, 64'h100);
      check("ok_bp_target", {32'd0, bp_upd_target}, 64'h140);
      check("ok_epoch", {62'd0, cur_epoch}, 64'd0);
      tick();
      check("ok_cdb_drained", {63'd0, cdb_valid}, 64'd0);
      check("ok_bp_pulse", {63'd0, bp_upd_valid}, 64'd0);

      // Mispredict with redirect held off for three cycles.
      drive(2'd0, 5'd9, 6'd3, 32'h304, 32'h300, 1'b1, 32'h2000);
      tick();
      bru_wb_valid = 1'b0;
      check("mp_epoch", {62'd0, cur_epoch}, 64'd1);
      check("mp_flush1", {63'd0, flush_valid}, 64'd1);
      check("mp_flush_rob", {59'd0, flush_rob_idx}, 64'd9);
      check("mp_ready1", {63'd0, bru_wb_ready}, 64'd0);
      check("mp_cdb_epoch", {62'd0, cdb_epoch}, 64'd0);
      check("mp_cdb_rob", {59'd0, cdb_rob_idx}, 64'd9);
      tick();
      check("mp_flush2", {63'd0, flush_valid}, 64'd1);
      check("mp_fe_early", {63'd0, fe_redirect_valid}, 64'd0);
      check("mp_ready2", {63'd0, bru_wb_ready}, 64'd0);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("mp_flush_off", {63'd0, flush_valid}, 64'd0);
         check("mp_fe_valid", {63'd0, fe_redirect_valid}, 64'd1);
         check("mp_fe_pc", {32'd0, fe_redirect_pc}, 64'h2000);
         check("mp_ready_hold", {63'd0, bru_wb_ready}, 64'd0);
      end
      fe_redirect_ready = 1'b1;
      tick();
      fe_redirect_ready = 1'b0;
      check("mp_fe_done", {63'd0, fe_redirect_valid}, 64'd0);
      check("mp_idle_ready", {63'd0, bru_wb_ready}, 64'd1);

      // Stale mispredict is consumed and dropped.
      drive(2'd0, 5'd7, 6'd7, 32'h77, 32'h500, 1'b1, 32'h9000);
      #1;
      check("stale_ready", {63'd0, bru_wb_ready}, 64'd1);
      tick();
      bru_wb_valid = 1'b0;
      check("stale_cdb", {63'd0, cdb_valid}, 64'd0);
      check("stale_bp", {63'd0, bp_upd_valid}, 64'd0);
      check("stale_flush", {63'd0, flush_valid}, 64'd0);
      check("stale_epoch", {62'd0, cur_epoch}, 64'd1);

      // Backpressure, then drain and reload in the same cycle.
      cdb_ready = 1'b0;
      drive(2'd1, 5'd3, 6'd30, 32'h11, 32'h600, 1'b0, 32'h0);
      tick();
      check("bp_full", {63'd0, cdb_valid}, 64'd1);
      drive(2'd1, 5'd4, 6'd31, 32'h22, 32'h700, 1'b0, 32'h0);
      #1;
      check("bp_ready_low", {63'd0, bru_wb_ready}, 64'd0);
      tick();
      check("bp_hold_rob", {59'd0, cdb_rob_idx}, 64'd3);
      check("bp_hold_data", {32'd0, cdb_data}, 64'h11);
      check("bp_no_upd", {63'd0, bp_upd_valid}, 64'd0);
      cdb_ready = 1'b1;
      #1;
      check("bp_ready_high", {63'd0, bru_wb_ready}, 64'd1);
      tick();
      bru_wb_valid = 1'b0;
      check("bp_reload_valid", {63'd0, cdb_valid}, 64'd1);
      check("bp_reload_rob", {59'd0, cdb_rob_idx}, 64'd4);
      check("bp_reload_data", {32'd0, cdb_data}, 64'h22);
      check("bp_reload_upd", {32'd0, bp_upd_pc}, 64'h700);
      tick();
      check("bp_drained", {63'd0, cdb_valid}, 64'd0);

      // Bring epoch to 3, then wrap through 0,1,2,3.
      mispredict_and_recover(2'd1, 2'd2);
      mispredict_and_recover(2'd2, 2'd3);
      mispredict_and_recover(2'd3, 2'd0);
      mispredict_and_recover(2'd0, 2'd1);
      mispredict_and_recover(2'd1, 2'd2);
      mispredict_and_recover(2'd2, 2'd3);

      // Reset during the first flush cycle aborts recovery.
      drive(2'd3, 5'd2, 6'd2, 32'h20, 32'h800, 1'b1, 32'h3000);
      tick();
      bru_wb_valid = 1'b0;
      check("rf_flush_on", {63'd0, flush_valid}, 64'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("rf_flush", {63'd0, flush_valid}, 64'd0);
      check("rf_fe", {63'd0, fe_redirect_valid}, 64'd0);
      check("rf_cdb", {63'd0, cdb_valid}, 64'd0);
      check("rf_bp", {63'd0, bp_upd_valid}, 64'd0);
      check("rf_epoch", {62'd0, cur_epoch}, 64'd0);
      check("rf_ready", {63'd0, bru_wb_ready}, 64'd1);
      tick(); tick(); tick();
      check("rf_no_redirect", {63'd0, fe_redirect_valid}, 64'd0);
      check("rf_still_ready", {63'd0, bru_wb_ready}, 64'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
